// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line in, received byte and FIFO write strobe out.
interface uart_receiver_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS
);

  logic                 uart_rxd;
  logic [DATA_BITS-1:0] rf_data;
  logic                 fr_wrreq;

  modport master (
    input  uart_rxd,
    output rf_data,
    output fr_wrreq
  );

  modport slave (
    output uart_rxd,
    input  rf_data,
    input  fr_wrreq
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer on the serial line plus the 3-sample majority voter.
// The vote is valid when the bit counter sits at MID_SAMPLE + 2.
module uart_rx_sync #(
  parameter int CNT_W = 4
) (
  input  logic             uart_clk,
  input  logic             rst_n,
  input  logic             i_rxd,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_rxd_s,
  output logic             o_vote
);
  import uart_pkg::*;

  logic r_meta;
  logic r_rxd_s;
  logic r_smp_a;
  logic r_smp_b;

  // Synchronizer chain and the first two vote samples; the third is the live rxd_s.
  always_ff @(posedge uart_clk) begin
    if (rst_n) begin
      r_meta  <= 1'b1;
      r_rxd_s <= 1'b1;
      r_smp_a <= 1'b1;
      r_smp_b <= 1'b1;
    end else begin
      r_meta  <= i_rxd;
      r_rxd_s <= r_meta;
      if (i_cnt == CNT_W'(MID_SAMPLE)) begin
        r_smp_a <= r_rxd_s;
      end
      if (i_cnt == CNT_W'(MID_SAMPLE + 1)) begin
        r_smp_b <= r_rxd_s;
      end
    end
  end

  assign o_rxd_s = r_rxd_s;
  assign o_vote  = majority3(r_smp_a, r_smp_b, r_rxd_s);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling; one FIFO write strobe per good frame.
// Note: rst_n is an active-high synchronous reset despite its name.
module uart_receiver #(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
  input  logic              uart_clk,
  input  logic              rst_n,
  uart_receiver_if.master   rx
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rf_data;
  logic                 r_wrreq;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_rf_data_nxt;
  logic                 w_wrreq_nxt;
  logic                 w_rxd_s;
  logic                 w_vote;
  logic                 w_decide;
  logic                 w_cnt_last;

  uart_rx_sync #(
    .CNT_W (CNT_W)
  ) u_sync (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .i_rxd    (rx.uart_rxd),
    .i_cnt    (r_cnt),
    .o_rxd_s  (w_rxd_s),
    .o_vote   (w_vote)
  );

  assign w_decide   = (r_cnt == CNT_W'(MID_SAMPLE + 2));
  assign w_cnt_last = (r_cnt == CNT_W'(OVERSAMPLE - 1));

  // State, counters, shift register and output registers.
  always_ff @(posedge uart_clk) begin
    if (rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_rf_data <= '0;
      r_wrreq   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_rf_data <= w_rf_data_nxt;
      r_wrreq   <= w_wrreq_nxt;
    end
  end

  // Next-state logic: frame sequencing, bit capture and strobe generation.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_cnt_last ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_rf_data_nxt = r_rf_data;
    w_wrreq_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        // The first cycle with rxd_s low is tick 0 of the start bit.
        if (!w_rxd_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      START: begin
        if (w_decide && w_vote) begin
          w_state_nxt = IDLE;
        end else if (w_cnt_last) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_decide) begin
          w_shift_nxt[r_idx] = w_vote;
        end else begin
          w_shift_nxt = r_shift;
        end
        if (w_cnt_last) begin
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      STOP: begin
        // Return early on a good stop bit so a back-to-back start edge is not missed.
        if (w_decide) begin
          if (w_vote) begin
            w_rf_data_nxt = r_shift;
            w_wrreq_nxt   = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            w_state_nxt   = WAIT_IDLE;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rxd_s) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign rx.rf_data  = r_rf_data;
  assign rx.fr_wrreq = r_wrreq;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven bit by bit and every
// expected byte with its strobe cycle goes to a scoreboard checked each cycle.
module tb_uart_receiver;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic uart_clk = 1'b0;
  logic rst      = 1'b1;

  uart_receiver_if ifc ();

  uart_receiver dut (
    .uart_clk (uart_clk),
    .rst_n    (rst),
    .rx       (ifc)
  );

  always #5 uart_clk = ~uart_clk;

  exp_t       sb[$];
  int         n_vec    = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  logic [7:0] model_rf = 8'h00;
  logic       prev_wr  = 1'b0;

  // Advance one clock, then check the strobe against the scoreboard and rf_data against the model.
  task automatic tick();
    logic rst_at_edge;
    exp_t e;
    rst_at_edge = rst;
    @(posedge uart_clk);
    #1;
    cyc++;
    if (rst_at_edge) model_rf = 8'h00;
    if (ifc.fr_wrreq === 1'b1) begin
      n_vec++;
      assert (prev_wr === 1'b0) else begin
        n_err++;
        $error("FAIL strobe_width: observed prev=%b now=1 at cycle %0d, expected prev=0", prev_wr, cyc);
      end
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_strobe: observed strobe at cycle %0d, expected none", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        assert (cyc === e.due) else begin
          n_err++;
          $error("FAIL strobe_time: observed cycle %0d, expected cycle %0d", cyc, e.due);
        end
        model_rf = e.data;
      end
    end
    n_vec++;
    assert (ifc.rf_data === model_rf) else begin
      n_err++;
      $error("FAIL rf_data: observed %h, expected %h at cycle %0d", ifc.rf_data, model_rf, cyc);
    end
    prev_wr = ifc.fr_wrreq;
  endtask

  // Drive one 10-bit frame; glitch_bit inverts tick 8 of that frame bit, rst_bit pulses reset at its tick 0.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit exp_pulse,
                            input int glitch_bit, input int rst_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    if (exp_pulse) sb.push_back('{data: d, due: cyc + 156});
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) begin
        ifc.uart_rxd = (i == glitch_bit && j == 8) ? ~f[i] : f[i];
        rst = (i == rst_bit && j == 0) ? 1'b1 : 1'b0;
        tick();
      end
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    ifc.uart_rxd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic check_drained(input string tag);
    n_vec++;
    assert (sb.size() === 0) else begin
      n_err++;
      $error("FAIL %s: observed %0d pending strobes, expected 0", tag, sb.size());
    end
  endtask

  initial begin
    // Reset held for 10 cycles on an idle line.
    ifc.uart_rxd = 1'b1;
    rst = 1'b1;
    repeat (10) tick();
    rst = 1'b0;
    n_vec++;
    assert (ifc.fr_wrreq === 1'b0) else begin
      n_err++;
      $error("FAIL reset_wrreq: observed %b, expected 0", ifc.fr_wrreq);
    end
    idle(20);
    n_vec++;
    assert (dut.r_state === uart_pkg::IDLE) else begin
      n_err++;
      $error("FAIL reset_state: observed %0d, expected IDLE", dut.r_state);
    end

    // Single frame.
    send_frame(8'h55, 1'b1, 1'b1, -1, -1);
    idle(20);
    check_drained("single_frame");

    // Back-to-back frames with no idle gap.
    send_frame(8'hA3, 1'b1, 1'b1, -1, -1);
    send_frame(8'h0F, 1'b1, 1'b1, -1, -1);
    idle(20);
    check_drained("back_to_back");

    // Framing error, line stuck low for three more bit times, then recovery.
    send_frame(8'h55, 1'b0, 1'b0, -1, -1);
    repeat (48) tick();
    n_vec++;
    assert (dut.r_state === uart_pkg::WAIT_IDLE) else begin
      n_err++;
      $error("FAIL framing_wait: observed state %0d, expected WAIT_IDLE", dut.r_state);
    end
    idle(20);
    n_vec++;
    assert (ifc.rf_data === 8'h0F) else begin
      n_err++;
      $error("FAIL framing_hold: observed %h, expected 0f", ifc.rf_data);
    end
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    idle(20);
    check_drained("after_framing");

    // 4-cycle low glitch on an idle line.
    ifc.uart_rxd = 1'b0;
    repeat (4) tick();
    idle(30);
    n_vec++;
    assert (dut.r_state === uart_pkg::IDLE) else begin
      n_err++;
      $error("FAIL glitch_state: observed %0d, expected IDLE", dut.r_state);
    end

    // One-cycle inversion at the middle sample of data bit 3.
    send_frame(8'h55, 1'b1, 1'b1, 4, -1);
    idle(20);
    check_drained("noise_frame");

    // Reset during data bit 4 of an all-ones frame, then a clean frame.
    send_frame(8'hFF, 1'b1, 1'b0, -1, 5);
    idle(10);
    n_vec++;
    assert (ifc.rf_data === 8'h00) else begin
      n_err++;
      $error("FAIL midframe_reset: observed %h, expected 00", ifc.rf_data);
    end
    send_frame(8'h81, 1'b1, 1'b1, -1, -1);
    idle(20);
    check_drained("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART serial-to-parallel receiver for 8N1 frames, sampled with a 16x oversampling clock. It sits between the external `uart_rxd` pin and the receive FIFO. For each valid frame it presents one byte on `rf_data` and issues a single-cycle write request on `fr_wrreq`.

## Interface
- `OVERSAMPLE`, default 16: `uart_clk` cycles per bit. `uart_clk` = baud × 16, i.e. 153.6 kHz at 9600 baud.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `uart_clk`, input, 1: sole clock; every register uses its rising edge.
- `rst_n`, input, 1: synchronous reset, active-high. Despite the `_n` suffix, a 1 sampled on a `uart_clk` edge resets the block.
- `uart_rxd`, input, 1: asynchronous serial line, idle high.
- `rf_data`, output, 8: last correctly received byte, held between frames.
- `fr_wrreq`, output, 1: FIFO write strobe, one `uart_clk` cycle wide per good frame.

## Operation
- **Input synchronizer**: 2-FF synchronizer on `uart_rxd`, reset to 1. All logic uses the synchronized value `rxd_s`.
- **Bit counting**: a tick counter `cnt` (0..15) and a bit index (0..DATA_BITS-1) position the sampling.
- **Sample vote**: each bit is sampled at `cnt` = 7, 8, 9. The bit value is the 2-of-3 majority and is decided at `cnt` = 9.
- **IDLE**: on `rxd_s` = 0, clear `cnt` and go to START.
- **START**: at `cnt` = 9, a majority 0 confirms the start bit; otherwise return to IDLE (glitch rejection). After the confirmed start bit reaches `cnt` = 15, go to DATA with bit index 0.
- **DATA**: shift the voted bit into bit[index], LSB first. At `cnt` = 15 of the last bit, go to STOP.
- **STOP**: at `cnt` = 9:
  - Majority 1: load `rf_data` from the shift register, pulse `fr_wrreq` for the next cycle, go to IDLE. The remaining half stop bit is not waited out, so the next start edge is accepted immediately.
  - Majority 0 (framing error): discard the byte, leave `rf_data` unchanged, no pulse, go to WAIT_IDLE.
- **WAIT_IDLE**: stay until `rxd_s` = 1, then go to IDLE. This prevents a stuck-low line from being decoded as repeated 0x00 frames.
- **Reset**: reset mid-frame aborts the frame with no `fr_wrreq`.

## Timing
- **Reset values**: `rf_data` = 8'h00, `fr_wrreq` = 0, state IDLE, `cnt` = 0, shift register 0, synchronizer flops 1.
- **Cycle reference**: cycle 0 is the first cycle with `rxd_s` low; this is 2 cycles after the `uart_rxd` falling edge.
- **Bit decisions**: start bit at cycle 9; data bit n at cycle 16·(n+1)+9; stop bit at cycle 153.
- **Write strobe**: `rf_data` updates and `fr_wrreq` is high during cycle 154, i.e. about 156 `uart_clk` cycles (≈1.016 ms at 9600 baud) after the line falls.
- **Strobe width**: `fr_wrreq` is never high for two consecutive cycles. `rf_data` is stable while `fr_wrreq` is high and until the next strobe.
- **Flow control**: none. The FIFO must accept every strobe.
- **Glitches**: a low pulse of 8 cycles or less that ends before `cnt` = 7 never leaves START.

## Structure
- Shared package `uart_pkg`:
  - state enum IDLE/START/DATA/STOP/WAIT_IDLE
  - constants OVERSAMPLE, DATA_BITS, MID_SAMPLE = 7
- Natural sub-module: `uart_rx_sync`, holding the 2-FF synchronizer plus the 3-sample majority voter.
- FSM, counters and shift register stay in the top module.

## Test plan
- **Reset**: hold `rst_n` = 1 for 10 cycles with `uart_rxd` = 1 → `rf_data` = 8'h00, `fr_wrreq` = 0, nothing changes afterwards.
- **Single frame**: send start, 0x55 LSB first, then stop bit 1, at 16 cycles per bit → exactly one `fr_wrreq` pulse about 156 cycles after the falling edge, with `rf_data` = 8'h55.
- **Back-to-back frames**: send 0xA3 then 0x0F with no idle gap → two pulses 160 cycles apart, `rf_data` = 8'hA3 then 8'h0F.
- **Glitch and noise**:
  - 4-cycle low pulse on an idle line → no pulse, state back to IDLE.
  - 1-cycle inversion at `cnt` = 8 of data bit 3 of 0x55 → still one pulse with 8'h55.
- **Framing error**: send 0x55 with stop bit 0 and hold the line low for 3 bit times → no pulse, `rf_data` keeps its old value. Then release high and send 0x3C → one pulse, `rf_data` = 8'h3C.
- **Reset mid-frame**: assert `rst_n` during data bit 4 for 1 cycle → no pulse, `rf_data` = 8'h00. A following complete 0x81 frame → one pulse, `rf_data` = 8'h81.
